im_loader: RTL and testbench

Instruction-memory writer for the 16-bit single-cycle core: accepts a byte stream over a valid/ready handshake, packs byte pairs into 16-bit instruction words, and writes them into a 16-entry instruction store. The core reads the same store through a combinational fetch port. The loader holds the core in reset until a program has been loaded. It replaces the hard-wired instruction ROM, so programs can be changed without re-synthesis.

---
 rtl/im_loader_pkg.sv | 25 ++
 rtl/im_loader_if.sv | 13 +
 rtl/im_array.sv | 29 ++
 rtl/im_loader.sv | 100 ++++++++++
 tb/tb_im_loader.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/im_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the loader state encoding, store geometry and byte-order rule.
package im_loader_pkg;

    localparam int IM_DEPTH = 16;
    localparam int WORD_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int CNT_W    = 5;

    // First byte of each pair lands in bits 7:0.
    localparam bit BYTE_ORDER_LE = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_t;

    function automatic logic [WORD_W-1:0] pack_word(input logic [7:0] first_b,
                                                    input logic [7:0] second_b);
        return BYTE_ORDER_LE ? {second_b, first_b} : {first_b, second_b};
    endfunction

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream handshake into the loader: valid/ready with an end-of-program marker.
// The producer holds in_byte/in_last stable until a cycle with in_ready high.
interface im_loader_if;

    logic       in_valid;
    logic [7:0] in_byte;
    logic       in_last;
    logic       in_ready;

    modport master (output in_valid, in_byte, in_last, input in_ready);
    modport slave  (input in_valid, in_byte, in_last, output in_ready);

endinterface

// File: rtl/im_array.sv
// 16x16 instruction store: one posedge write port, combinational read, async clear.
// Write visible on rdata right after the edge; no backpressure.
module im_array
    import im_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [IM_DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < IM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/im_loader.sv
// Packs a byte stream into 16-bit words in the instruction store, holding the core until done.
// One byte/cycle, DONE on the edge of the final byte; in_ready is a Moore output of the state.
module im_loader
    import im_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    im_loader_if.slave        s,
    input  logic [4:0]        pc,
    output logic [WORD_W-1:0] ir,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [CNT_W-1:0]  word_count
);

    state_t              state;
    state_t              state_nxt;
    logic [7:0]          lo_buf;
    logic                accept;
    logic                start;
    logic                we;
    logic                last_slot;
    logic [WORD_W-1:0]   wdata;
    logic                unused_pc0;

    assign accept     = s.in_valid & s.in_ready;
    assign start      = load_start & ((state == IDLE) || (state == DONE));
    assign last_slot  = (word_count == CNT_W'(IM_DEPTH - 1));
    assign wdata      = pack_word(lo_buf, s.in_byte);
    // pc is a byte address; instructions are word aligned.
    assign unused_pc0 = pc[0];

    always_comb begin
        state_nxt  = state;
        we         = 1'b0;
        s.in_ready = 1'b0;
        cpu_hold   = 1'b1;
        load_done  = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) state_nxt = LO;
            end
            LO: begin
                s.in_ready = 1'b1;
                if (accept) state_nxt = s.in_last ? DONE : HI;
            end
            HI: begin
                s.in_ready = 1'b1;
                if (accept) begin
                    we        = 1'b1;
                    state_nxt = (s.in_last || last_slot) ? DONE : LO;
                end
            end
            DONE: begin
                cpu_hold  = 1'b0;
                load_done = 1'b1;
                if (load_start) state_nxt = LO;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lo_buf     <= '0;
            word_count <= '0;
            load_err   <= 1'b0;
        end else if (start) begin
            word_count <= '0;
            load_err   <= 1'b0;
        end else if (accept && (state == LO)) begin
            lo_buf <= s.in_byte;
            // A lone low byte at end of program is dropped and flagged.
            if (s.in_last) load_err <= 1'b1;
        end else if (we && (word_count != CNT_W'(IM_DEPTH))) begin
            word_count <= word_count + CNT_W'(1);
        end
    end

    im_array u_array (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (word_count[ADDR_W-1:0]),
        .wdata (wdata),
        .raddr (pc[4:1]),
        .rdata (ir)
    );

endmodule

// File: tb/tb_im_loader.sv
// Randomized bench for im_loader against a program-level model of the store and load result.
module tb_im_loader;
    import im_loader_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_start = 1'b0;
    logic [4:0]  pc = 5'd6;
    logic [15:0] ir;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [4:0]  word_count;

    im_loader_if s ();

    im_loader dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .s          (s),
        .pc         (pc),
        .ir         (ir),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] ref_mem [16];
    logic [7:0]  bq [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one byte until accepted or max_cyc edges pass; returns just after the edge.
    task automatic offer(input logic [7:0] b, input logic last, input int max_cyc, output bit took);
        logic rdy;
        took = 1'b0;
        @(negedge clk);
        s.in_valid = 1'b1;
        s.in_byte  = b;
        s.in_last  = last;
        for (int k = 0; k < max_cyc && !took; k++) begin
            if (k > 0) @(negedge clk);
            rdy = s.in_ready;
            @(posedge clk);
            if (rdy) took = 1'b1;
        end
        #1;
        s.in_valid = 1'b0;
        s.in_last  = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
    endtask

    task automatic readback(input string tag);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            pc = 5'(2 * k + int'($urandom_range(0, 1)));
            #1;
            check(tag, ir, ref_mem[k]);
        end
    endtask

    // Load the program in bq; last_idx < 0 means in_last is never raised.
    task automatic do_load(input int last_idx, input int gapmode, input bit poke);
        int         c;
        int         nw;
        bit         err;
        bit         took;
        logic [7:0] lo;
        c   = bq.size();
        nw  = 0;
        err = 1'b0;
        lo  = 8'h00;
        for (int i = 0; i < bq.size(); i++) begin
            if (i % 2 == 0) begin
                lo = bq[i];
                if (i == last_idx) begin
                    err = 1'b1;
                    c   = i + 1;
                    break;
                end
            end else begin
                ref_mem[nw] = {bq[i], lo};
                nw++;
                if (i == last_idx || nw == 16) begin
                    c = i + 1;
                    break;
                end
            end
        end

        pulse_start();
        check("start_rdy", s.in_ready, 1);
        check("start_hold", cpu_hold, 1);
        check("start_done", load_done, 0);
        check("start_wc", word_count, 0);
        check("start_err", load_err, 0);

        for (int i = 0; i < c; i++) begin
            if (gapmode == 1 || (gapmode == 2 && $urandom_range(0, 1) == 1)) begin
                @(negedge clk);
                @(posedge clk);
            end
            if (poke && i == 4) begin
                pulse_start();
                check("start_ignored_wc", word_count, 2);
                check("start_ignored_rdy", s.in_ready, 1);
            end
            offer(bq[i], (i == last_idx), 4, took);
            check("accept", took, 1);
            if (!took) break;
            if (i < c - 1) begin
                check("hold_busy", cpu_hold, 1);
                check("wc_run", word_count, (i + 1) / 2);
            end
        end

        check("end_done", load_done, 1);
        check("end_hold", cpu_hold, 0);
        check("end_rdy", s.in_ready, 0);
        check("end_wc", word_count, nw);
        check("end_err", load_err, err);

        if (bq.size() > c) begin
            offer(bq[c], 1'b0, 3, took);
            check("extra_byte_held", took, 0);
            check("extra_wc", word_count, nw);
        end
        readback("store");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit took;
        int n;
        int li;
        s.in_valid = 1'b0;
        s.in_byte  = 8'h00;
        s.in_last  = 1'b0;
        for (int k = 0; k < 16; k++) ref_mem[k] = 16'h0000;

        // Reset values
        #12;
        check("rst_ir", ir, 16'h0000);
        check("rst_hold", cpu_hold, 1);
        check("rst_rdy", s.in_ready, 0);
        check("rst_wc", word_count, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_rst_ir", ir, 16'h0000);
        check("post_rst_hold", cpu_hold, 1);
        check("post_rst_done", load_done, 0);
        check("post_rst_err", load_err, 0);

        // Two-word program
        bq = '{8'h21, 8'hE4, 8'h22, 8'h02};
        do_load(3, 0, 1'b0);
        @(negedge clk);
        pc = 5'd2;
        #1;
        check("ir_pc2", ir, 16'h0222);

        // 33 bytes without in_last: the 32nd byte ends the load
        bq.delete();
        for (int i = 0; i < 33; i++) bq.push_back(8'($urandom));
        do_load(-1, 0, 1'b0);

        // Odd-length program: partial word dropped, error flagged and sticky
        bq = '{8'hAA, 8'hBB, 8'hCC};
        do_load(2, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", load_err, 1);

        // Gaps on every byte, plus an ignored mid-load start pulse
        bq.delete();
        for (int i = 0; i < 10; i++) bq.push_back(8'($urandom));
        do_load(9, 1, 1'b1);

        // Reset between the two bytes of word 3
        bq.delete();
        for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            offer(bq[i], 1'b0, 4, took);
            check("pre_rst_accept", took, 1);
        end
        #2;
        reset = 1'b0;
        #1;
        check("midrst_hold", cpu_hold, 1);
        check("midrst_rdy", s.in_ready, 0);
        check("midrst_wc", word_count, 0);
        check("midrst_done", load_done, 0);
        for (int k = 0; k < 16; k++) ref_mem[k] = 16'h0000;
        readback("midrst_store");
        @(negedge clk);
        reset = 1'b1;
        bq.delete();
        for (int i = 0; i < 4; i++) bq.push_back(8'($urandom));
        do_load(3, 2, 1'b0);

        // Random programs
        for (int t = 0; t < 12; t++) begin
            bq.delete();
            if ($urandom_range(0, 3) == 0) begin
                n  = 32 + int'($urandom_range(0, 2));
                li = -1;
            end else begin
                n  = int'($urandom_range(1, 32));
                li = n - 1;
            end
            for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
            do_load(li, 2, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
